// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and the unified memory.
// slave = arbiter side; master = requesters and memory side.
interface mem_port_arbiter_if;
  // Handshake: x_req is held high with stable fields until the one-cycle x_ack pulse;
  // the arbiter captures the fields at grant, so the requester may change them after ack.
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [2:0]  d_fn;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [2:0]  mem_fn;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_fn, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_err, d_rdata, mem_en, mem_fn, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_fn, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_err, d_rdata, mem_en, mem_fn, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory between instruction fetch (I) and load/store (D).
// D wins by default; a starvation counter forces an I grant after STARVE_LIMIT D grants.
`ifndef MEM_LB
`define MEM_LB  3'd0
`define MEM_LBU 3'd1
`define MEM_LH  3'd2
`define MEM_LHU 3'd3
`define MEM_LW  3'd4
`define MEM_SB  3'd5
`define MEM_SH  3'd6
`define MEM_SW  3'd7
`endif

module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [2:0]          dbg_state,
    output logic [CW-1:0]       dbg_starve
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4,
        ERR_D   = 3'd5
    } state_t;

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state, state_nxt;
    logic [CW-1:0] starve, starve_nxt;
    logic          grant_i, grant_d;
    logic          d_mis, d_is_store, d_store;

    // All eight 3-bit codes are defined, so every code reaches memory unchanged.
    always_comb begin
        d_mis      = 1'b0;
        d_is_store = 1'b0;
        case (bus.d_fn)
            `MEM_LW:           d_mis = (bus.d_addr[1:0] != 2'b00);
            `MEM_LH, `MEM_LHU: d_mis = bus.d_addr[0];
            `MEM_SW: begin
                d_mis      = (bus.d_addr[1:0] != 2'b00);
                d_is_store = 1'b1;
            end
            `MEM_SH: begin
                d_mis      = bus.d_addr[0];
                d_is_store = 1'b1;
            end
            `MEM_SB:           d_is_store = 1'b1;
            default:           d_mis = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ISSUE_I: state_nxt = RESP_I;
            ISSUE_D: state_nxt = RESP_D;
            default: begin
                if (bus.i_req && (!bus.d_req || starve == LIMIT)) begin
                    grant_i    = 1'b1;
                    state_nxt  = ISSUE_I;
                    starve_nxt = '0;
                end else if (bus.d_req) begin
                    grant_d   = 1'b1;
                    state_nxt = d_mis ? ERR_D : ISSUE_D;
                    if (!bus.i_req)
                        starve_nxt = '0;
                    else if (starve != LIMIT)
                        starve_nxt = starve + CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            starve        <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_fn    <= `MEM_LW;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            d_store       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve     <= starve_nxt;
            bus.mem_en <= grant_i | (grant_d & ~d_mis);
            if (grant_i) begin
                bus.mem_fn    <= `MEM_LW;
                bus.mem_addr  <= bus.i_addr;
                bus.mem_wdata <= '0;
            end else if (grant_d && !d_mis) begin
                bus.mem_fn    <= bus.d_fn;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
                d_store       <= d_is_store;
            end
            bus.i_ack <= (state == ISSUE_I);
            bus.d_ack <= (state == ISSUE_D) | (grant_d & d_mis);
            bus.d_err <= grant_d & d_mis;
        end
    end

    // Memory data arrives in the response cycle itself, so it is steered straight through.
    assign bus.i_rdata = (state == RESP_I) ? bus.mem_rdata : '0;
    assign bus.d_rdata = (state == RESP_D && !d_store) ? bus.mem_rdata : '0;

    assign dbg_state  = state;
    assign dbg_starve = starve;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed latency/starvation/reset cases plus
// random sequential traffic, with responses checked against an expected queue.
module tb_mem_port_arbiter;

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3;
  localparam logic [2:0] LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  logic [2:0] dbg_starve;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  logic [33:0] exp_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem_arr [0:255];
  logic [31:0] mem_q = '0;
  logic        mem_loaded = 1'b0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .dbg_state  (dbg_state),
    .dbg_starve (dbg_starve)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_0000 ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  // memory model: registered read, byte-lane writes
  assign bus.mem_rdata = mem_q;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      case (bus.mem_fn)
        SW: mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
        SH: mem_arr[bus.mem_addr[9:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
        SB: mem_arr[bus.mem_addr[9:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
        default: mem_q <= mem_arr[bus.mem_addr[9:2]];
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic mis_model(input logic [2:0] fn, input logic [31:0] a);
    case (fn)
      LW, SW:      return a[1:0] != 2'b00;
      LH, LHU, SH: return a[0];
      default:     return 1'b0;
    endcase
  endfunction

  // scoreboard entry: {is_d, err, data}
  task automatic push_d(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
    if (mis_model(fn, a)) exp_q.push_back({1'b1, 1'b1, 32'h0});
    else begin
      case (fn)
        SW: begin ref_mem[a[9:2]] = wd; exp_q.push_back({1'b1, 1'b0, 32'h0}); end
        SH: begin ref_mem[a[9:2]][{a[1], 4'b0000} +: 16] = wd[15:0]; exp_q.push_back({1'b1, 1'b0, 32'h0}); end
        SB: begin ref_mem[a[9:2]][{a[1:0], 3'b000} +: 8] = wd[7:0]; exp_q.push_back({1'b1, 1'b0, 32'h0}); end
        default: exp_q.push_back({1'b1, 1'b0, ref_mem[a[9:2]]});
      endcase
    end
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_q.push_back({1'b0, 1'b0, ref_mem[a[9:2]]});
  endtask

  // response monitor
  always @(negedge clk) begin
    if (!rst && (bus.i_ack || bus.d_ack)) begin
      check("ack_excl", {63'h0, bus.i_ack & bus.d_ack}, 64'h0);
      if (exp_q.size() == 0) check("sb_unexpected_ack", 64'h1, 64'h0);
      else check("sb_resp", {30'h0, bus.d_ack, bus.d_err, bus.d_ack ? bus.d_rdata : bus.i_rdata},
                 {30'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_ack(input bit want_d, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (want_d ? bus.d_ack : bus.i_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(tag, 64'h0, 64'h1);
  endtask

  // driver tasks
  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = a;
    push_i(a);
    wait_ack(1'b0, "fetch_timeout");
    bus.i_req = 1'b0;
  endtask

  task automatic d_access(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_fn = fn; bus.d_addr = a; bus.d_wdata = wd;
    push_d(fn, a, wd);
    wait_ack(1'b1, "d_timeout");
    bus.d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    int s;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_fn = LB; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", {63'h0, bus.mem_en}, 64'h0);
    check("rst_mem_fn", {61'h0, bus.mem_fn}, {61'h0, LW});
    check("rst_mem_addr", {32'h0, bus.mem_addr}, 64'h0);
    check("rst_acks", {61'h0, bus.i_ack, bus.d_ack, bus.d_err}, 64'h0);
    check("rst_state", {61'h0, dbg_state}, 64'h0);
    check("rst_starve", {61'h0, dbg_starve}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // fetch latency
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    push_i(32'h100);
    @(posedge clk); #1;
    check("t1_mem_en", {63'h0, bus.mem_en}, 64'h1);
    check("t1_mem_addr", {32'h0, bus.mem_addr}, 64'h100);
    check("t1_mem_fn", {61'h0, bus.mem_fn}, {61'h0, LW});
    check("t1_early_ack", {63'h0, bus.i_ack}, 64'h0);
    @(posedge clk); #1;
    check("t1_i_ack", {63'h0, bus.i_ack}, 64'h1);
    check("t1_mem_en_off", {63'h0, bus.mem_en}, 64'h0);
    bus.i_req = 1'b0;

    // store
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_fn = SW; bus.d_addr = 32'h204; bus.d_wdata = 32'hDEADBEEF;
    push_d(SW, 32'h204, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t2_mem_en", {63'h0, bus.mem_en}, 64'h1);
    check("t2_mem_fn", {61'h0, bus.mem_fn}, {61'h0, SW});
    check("t2_mem_wdata", {32'h0, bus.mem_wdata}, 64'hDEADBEEF);
    @(posedge clk); #1;
    check("t2_d_ack", {62'h0, bus.d_ack, bus.d_err}, 64'h2);
    bus.d_req = 1'b0;
    d_access(LW, 32'h204, 32'h0);

    // misaligned load
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_fn = LH; bus.d_addr = 32'h203;
    push_d(LH, 32'h203, 32'h0);
    @(posedge clk); #1;
    check("t3_err_ack", {62'h0, bus.d_ack, bus.d_err}, 64'h3);
    check("t3_mem_en", {63'h0, bus.mem_en}, 64'h0);
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    check("t3_mem_en_after", {63'h0, bus.mem_en}, 64'h0);
    check("t3_ack_drop", {63'h0, bus.d_ack}, 64'h0);

    // back-to-back fetches
    @(negedge clk);
    c0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    push_i(32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b0, "t6_timeout");
      check("t6_ack_cycle", 64'(cyc - c0), 64'(2 * (k + 1)));
      if (k < 2) begin
        bus.i_addr = 32'(4 * (k + 1));
        push_i(32'(4 * (k + 1)));
      end else bus.i_req = 1'b0;
    end

    // starvation: both requests held, grant order from the bench's own counter
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_fn = LW; bus.d_addr = 32'h80;
    s = 0;
    for (int k = 0; k < 10; k++) begin
      if (s == 4) begin push_i(32'h40); s = 0; end
      else begin push_d(LW, 32'h80, 32'h0); s++; end
    end
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) n++;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("t4_ack_count", 64'(n), 64'd10);

    // random sequential traffic
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) fetch({22'h0, 8'($urandom_range(0, 255)), 2'b00});
      else d_access(3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom);
    end

    // reset during ISSUE_D of a byte store
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_fn = SB; bus.d_addr = 32'h301; bus.d_wdata = 32'h0000_00A5;
    @(posedge clk); #1;
    check("t5_issue", {60'h0, bus.mem_en, bus.mem_fn}, {60'h0, 1'b1, SB});
    check("t5_starve_pre", {61'h0, dbg_starve}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_mem_en_drop", {63'h0, bus.mem_en}, 64'h0);
    check("t5_state", {61'h0, dbg_state}, 64'h0);
    check("t5_starve", {61'h0, dbg_starve}, 64'h0);
    check("t5_no_ack", {62'h0, bus.d_ack, bus.i_ack}, 64'h0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_write", {32'h0, mem_arr[8'hC0]}, {32'h0, ref_mem[8'hC0]});

    repeat (4) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
